vga_sync_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 20 ++
 rtl/pix_en_div.sv | 27 ++
 rtl/vga_sync_gen.sv | 101 ++++++++++
 tb/tb_vga_sync_gen.sv | 137 +++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants shared by the sync generator and the renderer.
// Horizontal positions are sync-relative: visible pixels start at H_VIS_START.
package vga_timing_pkg;
  localparam int CLK_DIV  = 4;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;

  localparam int H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_VIS_START = H_SYNC + H_BP;
  localparam int H_VIS_END   = H_VIS_START + H_ACTIVE;
  localparam int V_VIS_START = V_SYNC + V_BP;
  localparam int V_VIS_END   = V_VIS_START + V_ACTIVE;
endpackage

// File: rtl/pix_en_div.sv
// Pixel-enable divider: registered one-clock pulse every CLK_DIV clocks.
// First pulse appears CLK_DIV clocks after reset release; no backpressure.
module pix_en_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_en
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] r_div;
  logic          r_pix_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div    <= '0;
      r_pix_en <= 1'b0;
    end else begin
      r_pix_en <= (r_div == DIV_LAST);
      r_div    <= (r_div == DIV_LAST) ? '0 : r_div + DW'(1);
    end
  end

  assign pix_en = r_pix_en;
endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster generator: counters, sync/bright decode and frame tick, all registered together.
// Decode uses next-state counters so syncs/bright have zero skew against hCount/vCount.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int P_CLK_DIV  = CLK_DIV,
  parameter int P_H_SYNC   = H_SYNC,
  parameter int P_H_BP     = H_BP,
  parameter int P_H_ACTIVE = H_ACTIVE,
  parameter int P_H_FP     = H_FP,
  parameter int P_V_SYNC   = V_SYNC,
  parameter int P_V_BP     = V_BP,
  parameter int P_V_ACTIVE = V_ACTIVE,
  parameter int P_V_FP     = V_FP
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        pix_en,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        hSync,
  output logic        vSync,
  output logic        bright,
  output logic        frame_tick,
  output logic [15:0] frame_count
);
  localparam int HT  = P_H_SYNC + P_H_BP + P_H_ACTIVE + P_H_FP;
  localparam int VT  = P_V_SYNC + P_V_BP + P_V_ACTIVE + P_V_FP;
  localparam logic [9:0] H_LAST = 10'(HT - 1);
  localparam logic [9:0] V_LAST = 10'(VT - 1);
  localparam logic [9:0] H_SYNC_END = 10'(P_H_SYNC);
  localparam logic [9:0] V_SYNC_END = 10'(P_V_SYNC);
  localparam logic [9:0] H_VS = 10'(P_H_SYNC + P_H_BP);
  localparam logic [9:0] H_VE = 10'(P_H_SYNC + P_H_BP + P_H_ACTIVE);
  localparam logic [9:0] V_VS = 10'(P_V_SYNC + P_V_BP);
  localparam logic [9:0] V_VE = 10'(P_V_SYNC + P_V_BP + P_V_ACTIVE);

  logic        w_pix_en;
  logic [9:0]  w_h_nxt;
  logic [9:0]  w_v_nxt;
  logic        w_tick;
  logic [9:0]  r_h;
  logic [9:0]  r_v;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_bright;
  logic        r_tick;
  logic [15:0] r_fc;

  pix_en_div #(.CLK_DIV(P_CLK_DIV)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (w_pix_en)
  );

  always_comb begin
    w_h_nxt = r_h;
    w_v_nxt = r_v;
    if (w_pix_en) begin
      if (r_h == H_LAST) begin
        w_h_nxt = '0;
        w_v_nxt = (r_v == V_LAST) ? '0 : r_v + 10'd1;
      end else begin
        w_h_nxt = r_h + 10'd1;
      end
    end
  end

  // Only the pixel step that lands on (0, V_VE) fires; holding there between enables does not.
  assign w_tick = w_pix_en && (w_h_nxt == '0) && (w_v_nxt == V_VE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h      <= '0;
      r_v      <= '0;
      r_hsync  <= 1'b0;
      r_vsync  <= 1'b0;
      r_bright <= 1'b0;
      r_tick   <= 1'b0;
      r_fc     <= '0;
    end else begin
      r_h      <= w_h_nxt;
      r_v      <= w_v_nxt;
      r_hsync  <= (w_h_nxt >= H_SYNC_END);
      r_vsync  <= (w_v_nxt >= V_SYNC_END);
      r_bright <= (w_h_nxt >= H_VS) && (w_h_nxt < H_VE) &&
                  (w_v_nxt >= V_VS) && (w_v_nxt < V_VE);
      r_tick   <= w_tick;
      if (w_tick) r_fc <= r_fc + 16'd1;
    end
  end

  assign pix_en      = w_pix_en;
  assign hCount      = r_h;
  assign vCount      = r_v;
  assign hSync       = r_hsync;
  assign vSync       = r_vsync;
  assign bright      = r_bright;
  assign frame_tick  = r_tick;
  assign frame_count = r_fc;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size and reduced rasters checked every clock against
// a closed-form model derived from the number of clocks since reset release.
module tb_vga_sync_gen;
  typedef struct packed {
    logic        pe;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        br;
    logic        ft;
    logic [15:0] fc;
  } obs_t;

  // reduced raster: 17 x 11 pixels, 3 clocks per pixel -> 561 clocks per frame
  localparam int S_D = 3, S_HS = 4, S_HB = 3, S_HA = 8, S_HF = 2;
  localparam int S_VS = 2, S_VB = 3, S_VA = 4, S_VF = 2;
  localparam int S_FRAME = S_D * (S_HS + S_HB + S_HA + S_HF) * (S_VS + S_VB + S_VA + S_VF);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        f_pe, f_hs, f_vs, f_br, f_ft, s_pe, s_hs, s_vs, s_br, s_ft;
  logic [9:0]  f_h, f_v, s_h, s_v;
  logic [15:0] f_fc, s_fc;

  vga_sync_gen dut_f (
    .clk(clk), .rst_n(rst_n), .pix_en(f_pe), .hCount(f_h), .vCount(f_v),
    .hSync(f_hs), .vSync(f_vs), .bright(f_br), .frame_tick(f_ft), .frame_count(f_fc)
  );

  vga_sync_gen #(
    .P_CLK_DIV(S_D), .P_H_SYNC(S_HS), .P_H_BP(S_HB), .P_H_ACTIVE(S_HA), .P_H_FP(S_HF),
    .P_V_SYNC(S_VS), .P_V_BP(S_VB), .P_V_ACTIVE(S_VA), .P_V_FP(S_VF)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .pix_en(s_pe), .hCount(s_h), .vCount(s_v),
    .hSync(s_hs), .vSync(s_vs), .bright(s_br), .frame_tick(s_ft), .frame_count(s_fc)
  );

  int n_chk = 0;
  int n_fail = 0;
  int k = 0;            // clock edges since reset release (0 while in reset)
  int bright_cnt = 0;
  int last_tick_k = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (clk %0d after release)", tag, obs, exp, k);
    end
  endtask

  // Raster position is simply the number of whole pixel periods elapsed.
  function automatic obs_t ref_model(input int kk, input int d, input int hs, input int hb,
                                     input int ha, input int hf, input int vs, input int vb,
                                     input int va, input int vf);
    obs_t m;
    int ht, vt, ve, p, h, v, first;
    ht = hs + hb + ha + hf;
    vt = vs + vb + va + vf;
    ve = vs + vb + va;
    p  = (kk <= 0) ? 0 : (kk - 1) / d;
    h  = p % ht;
    v  = (p / ht) % vt;
    first = ht * ve;
    m.pe = (kk > 0) && (kk % d == 0);
    m.h  = 10'(h);
    m.v  = 10'(v);
    m.hs = (h >= hs);
    m.vs = (v >= vs);
    m.br = (h >= hs + hb) && (h < hs + hb + ha) && (v >= vs + vb) && (v < ve);
    m.ft = (kk > 1) && ((kk - 1) % d == 0) && (h == 0) && (v == ve);
    m.fc = (p >= first) ? 16'((p - first) / (ht * vt) + 1) : 16'd0;
    return m;
  endfunction

  task automatic compare(input string pfx, input obs_t got, input obs_t exp);
    check({pfx, ".pix_en"},      32'(got.pe), 32'(exp.pe));
    check({pfx, ".hCount"},      32'(got.h),  32'(exp.h));
    check({pfx, ".vCount"},      32'(got.v),  32'(exp.v));
    check({pfx, ".hSync"},       32'(got.hs), 32'(exp.hs));
    check({pfx, ".vSync"},       32'(got.vs), 32'(exp.vs));
    check({pfx, ".bright"},      32'(got.br), 32'(exp.br));
    check({pfx, ".frame_tick"},  32'(got.ft), 32'(exp.ft));
    check({pfx, ".frame_count"}, 32'(got.fc), 32'(exp.fc));
  endtask

  task automatic step();
    obs_t gf, gs, ef, es;
    @(posedge clk);
    k = rst_n ? k + 1 : 0;
    #1;
    gf = '{f_pe, f_h, f_v, f_hs, f_vs, f_br, f_ft, f_fc};
    gs = '{s_pe, s_h, s_v, s_hs, s_vs, s_br, s_ft, s_fc};
    ef = ref_model(k, 4, 96, 48, 640, 16, 2, 33, 480, 10);
    es = ref_model(k, S_D, S_HS, S_HB, S_HA, S_HF, S_VS, S_VB, S_VA, S_VF);
    compare("full", gf, ef);
    compare("small", gs, es);

    // aggregate frame properties on the reduced raster
    if (k == 0) begin
      bright_cnt  = 0;
      last_tick_k = 0;
    end else begin
      if (s_pe === 1'b1 && s_br === 1'b1 && k <= S_FRAME) bright_cnt++;
      if (k == S_FRAME) check("small.bright_pixels_per_frame", 32'(bright_cnt), 32'(S_HA * S_VA));
      if (s_ft === 1'b1) begin
        if (last_tick_k > 0) check("small.tick_period", 32'(k - last_tick_k), 32'(S_FRAME));
        last_tick_k = k;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    // a few full-size lines plus several reduced frames without interruption
    repeat (10000) step();
    // random mid-frame resets of random width
    for (int i = 0; i < 8; i++) begin
      int run_len;
      int rst_len;
      run_len = int'($urandom_range(40, 1500));
      rst_len = int'($urandom_range(1, 3));
      repeat (run_len) step();
      rst_n = 1'b0;
      repeat (rst_len) step();
      rst_n = 1'b1;
    end
    repeat (2 * S_FRAME) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
